paralelo_serial_n: RTL

PARALELO_SERIAL_N -- requirements
Module: paralelo_serial_n

---
 rtl/paralelo_serial_n.sv | 103 ++++++++++
 1 files changed

// File: rtl/paralelo_serial_n.sv
// Parallel-to-serial converter: one-entry holding register feeding a WIDTH-bit
// shifter; IDLE_WORD fills every word slot that has no pending data.
module paralelo_serial_n #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(8'hBC),
    parameter bit              MSB_FIRST = 1'b1
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             out_serial,
    output logic             out_valid,
    output logic             word_start
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             out_serial_q, out_serial_d;
    logic             out_valid_q, out_valid_d;
    logic             word_start_q, word_start_d;

    logic             accept;
    logic             boundary;
    logic [WIDTH-1:0] word_sel;

    // Handshake: valid_in/ready_out transfer on a rising edge when both are 1.
    // ready_out comes straight from the hold_full flop, so the producer never
    // sees a combinational path back from its own valid_in or in_data.
    assign ready_out = !hold_full_q;

    always_comb begin
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        out_serial_d = out_serial_q;
        out_valid_d  = out_valid_q;
        word_start_d = 1'b0;

        accept   = valid_in && !hold_full_q;
        boundary = (bit_cnt_q == '0);
        // Boundary looks at the pre-edge flag, so a word accepted on this very
        // edge waits in the holding register for the next boundary.
        word_sel = hold_full_q ? hold_q : IDLE_WORD;

        if (boundary) begin
            shift_d      = word_sel;
            out_serial_d = MSB_FIRST ? word_sel[WIDTH-1] : word_sel[0];
            out_valid_d  = hold_full_q;
            word_start_d = 1'b1;
            bit_cnt_d    = CNT_W'(1);
            if (hold_full_q) begin
                hold_full_d = 1'b0;
            end
        end else begin
            if (MSB_FIRST) begin
                shift_d      = shift_q << 1;
                out_serial_d = shift_q[WIDTH-2];
            end else begin
                shift_d      = shift_q >> 1;
                out_serial_d = shift_q[1];
            end
            bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + 1'b1;
        end

        if (accept) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            out_serial_q <= 1'b0;
            out_valid_q  <= 1'b0;
            word_start_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            out_serial_q <= out_serial_d;
            out_valid_q  <= out_valid_d;
            word_start_q <= word_start_d;
        end
    end

    assign out_serial = out_serial_q;
    assign out_valid  = out_valid_q;
    assign word_start = word_start_q;

endmodule
